logic_op_sequencer: RTL and testbench
=====================================

// Module: logic_op_sequencer
// PURPOSE
//  Sequential command front end for the logic datapath.
//  - Accepts one operation (A, B, opcode S) over a valid/ready input handshake.
//  - Executes AND/OR/XOR in one cycle; executes shifts iteratively, one bit per clock.
//  - Returns the result with zero/invalid flags over a valid/ready output handshake.
//  - Sits between the operand/control source (register file or control FSM) and the
//    result consumer.
// PARAMETERS
//  NUM_BITS   4   operand/result width; legal values >= 2
// PORTS
//  clk        in   1          single clock, rising edge
//  rst        in   1          asynchronous, active-low reset
//  in_valid   in   1          command present on A/B/S
//  in_ready   out  1          block can accept a command (IDLE only)
//  A          in   NUM_BITS   first operand / value to shift
//  B          in   NUM_BITS   second operand / unsigned shift amount
//  S          in   3          opcode: 0 AND, 1 OR, 2 XOR, 3 LSHIFT, 4 RSHIFT, 5-7 invalid
//  out_valid  out  1          R/Z/ERR hold a valid result
//  out_ready  in   1          consumer takes result
//  R          out  NUM_BITS   registered result
//  Z          out  1          R == 0
//  ERR        out  1          opcode was 5-7
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, in_ready=1, out_valid=0, R=0, Z=0, ERR=0,
//    shift counter=0. Any in-flight command is abandoned; no partial result is emitted.
//  - States:
//    - IDLE:  in_ready=1. On in_valid at a rising edge: latch A, B, S.
//      - S 0-2: R <= A op B; go to DONE.
//      - S 5-7: R <= 0, ERR <= 1; go to DONE.
//      - S 3/4: R <= A, cnt <= min(B, NUM_BITS).
//        - cnt==0: go to DONE.
//        - otherwise: go to SHIFT.
//    - SHIFT: in_ready=0. Each cycle, shift R by 1 (logical, zero fill; left for S=3,
//      right for S=4) and decrement cnt. When cnt reaches 1 on the current cycle, go to DONE.
//    - DONE:  out_valid=1. R, Z and ERR stay stable until out_ready=1 is sampled; then
//      out_valid <= 0 and go to IDLE.
//  - Latency (acceptance edge -> first edge with out_valid=1):
//    - logic ops and invalid opcodes: 1 cycle.
//    - shifts: 1 + min(B, NUM_BITS) cycles.
//  - Throughput: one command outstanding. in_ready=0 in SHIFT and DONE, so the next
//    command is accepted the cycle after the out handshake (no same-cycle overlap).
//  - Shift amount: B is read as unsigned. Any B >= NUM_BITS clamps to NUM_BITS, giving
//    R=0. Counter width is $clog2(NUM_BITS+1).
//  - Flags:
//    - Z is derived from the final R, registered on entry to DONE.
//    - ERR is cleared on every new acceptance.
//  - Ignored inputs:
//    - in_valid outside IDLE has no effect.
//    - A/B/S changes after acceptance have no effect.
//    - out_ready outside DONE has no effect.
// STRUCTURE
//  - Shared package logic_pkg:
//    - typedef enum logic [2:0] op_t {OP_AND, OP_OR, OP_XOR, OP_LSH, OP_RSH};
//      values 5-7 are invalid.
//    - typedef enum state_t {IDLE, SHIFT, DONE}.
//  - One natural sub-module: shift_step. Combinational single-bit logical shift,
//    parameterised by NUM_BITS, with a direction input. Instantiated once on the
//    R register path.
//  - AND/OR/XOR are computed inline on the latched operands.
// TESTING  (NUM_BITS=4)
//  1. AND, A=1100 B=1010 S=0 -> R=1000, Z=0, ERR=0; out_valid 1 cycle after acceptance.
//  2. LSHIFT, A=0011 B=0010 S=3 -> R=1100, Z=0; out_valid exactly 3 cycles after
//     acceptance; in_ready=0 throughout.
//  3. RSHIFT, A=1000 B=0111 S=4 -> shift clamped to 4 -> R=0000, Z=1; latency 5 cycles.
//     Also B=0000 -> R=A, latency 1 cycle.
//  4. Invalid opcode, S=6 A=1111 -> R=0000, ERR=1, Z=1, latency 1. The following XOR
//     command clears ERR to 0.
//  5. Backpressure: hold out_ready=0 for 3 cycles while pulsing in_valid with a new
//     command -> R/Z/ERR stay stable, in_ready=0, the new command is not accepted.
//     Once out_ready=1: out_valid drops, in_ready=1 on the next cycle.
//  6. Reset mid-operation: assert rst=0 during SHIFT (LSHIFT B=3, cycle 2)
//     -> outputs go to reset values immediately, with no out_valid. After release,
//     OR A=0101 B=0010 -> R=0111.

Source files
------------

// File: rtl/logic_pkg.sv
// Shared types for the logic datapath: opcodes and the sequencer state encoding.
package logic_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_LSH = 3'd3,
    OP_RSH = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One-bit logical shift with zero fill; left when left=1, otherwise right.
module shift_step #(
  parameter int NUM_BITS = 4
) (
  input  logic [NUM_BITS-1:0] din,
  input  logic                left,
  output logic [NUM_BITS-1:0] dout
);

  assign dout = left ? {din[NUM_BITS-2:0], 1'b0} : {1'b0, din[NUM_BITS-1:1]};

endmodule

// File: rtl/logic_op_sequencer.sv
// Command front end: one-cycle AND/OR/XOR, iterative one-bit-per-clock shifts,
// result returned with zero/invalid flags.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready is high only in IDLE; out_valid is high only in DONE, and R/Z/ERR hold
// steady there until out_ready is sampled high.
module logic_op_sequencer
  import logic_pkg::*;
#(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] A,
  input  logic [NUM_BITS-1:0] B,
  input  logic [2:0]          S,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] R,
  output logic                Z,
  output logic                ERR,
  output logic [1:0]          dbg_state
);

  localparam int CW = $clog2(NUM_BITS + 1);

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] r_q, r_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                left_q, left_d;
  logic                z_q, z_d;
  logic                err_q, err_d;
  logic [NUM_BITS-1:0] shifted;
  logic [NUM_BITS-1:0] logic_res;
  logic [CW-1:0]       amt;
  op_t                 op;

  shift_step #(.NUM_BITS(NUM_BITS)) u_shift_step (
    .din  (r_q),
    .left (left_q),
    .dout (shifted)
  );

  // Shift amounts of NUM_BITS or more all produce zero, so clamp the count.
  assign amt = (32'(B) >= NUM_BITS) ? CW'(NUM_BITS) : CW'(B);
  assign op  = op_t'(S);

  always_comb begin
    logic_res = '0;
    case (op)
      OP_AND:  logic_res = A & B;
      OP_OR:   logic_res = A | B;
      OP_XOR:  logic_res = A ^ B;
      default: logic_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      z_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    z_d     = z_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          err_d  = 1'b0;
          left_d = (op == OP_LSH);
          case (op)
            OP_AND, OP_OR, OP_XOR: begin
              r_d     = logic_res;
              z_d     = (logic_res == '0);
              state_d = DONE;
            end
            OP_LSH, OP_RSH: begin
              r_d   = A;
              cnt_d = amt;
              if (amt == '0) begin
                z_d     = (A == '0);
                state_d = DONE;
              end else begin
                state_d = SHIFT;
              end
            end
            default: begin
              r_d     = '0;
              z_d     = 1'b1;
              err_d   = 1'b1;
              state_d = DONE;
            end
          endcase
        end
      end
      SHIFT: begin
        // The last shift and the move to DONE share one edge.
        r_d   = shifted;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          z_d     = (shifted == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign R         = r_q;
  assign Z         = z_q;
  assign ERR       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Self-checking bench for logic_op_sequencer with NUM_BITS=4.
module tb_logic_op_sequencer;

  localparam int N = 4;
  localparam int MAX_LAT = 2 * N + 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A, B, R;
  logic [2:0]   S;
  logic         out_valid, out_ready, Z, ERR;
  logic [1:0]   dbg_state;

  logic [N+1:0] exp_q[$];
  int           lat_q[$];
  int           passed = 0;
  int           total  = 0;

  logic_op_sequencer #(.NUM_BITS(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .S         (S),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R         (R),
    .Z         (Z),
    .ERR       (ERR),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference result packed as {err, z, r}.
  function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic [2:0] s);
    logic [N-1:0] r;
    logic         e;
    r = '0;
    e = 1'b0;
    case (s)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = (int'(b) >= N) ? '0 : (a << b);
      3'd4: r = (int'(b) >= N) ? '0 : (a >> b);
      default: e = 1'b1;
    endcase
    return {e, (r == '0), r};
  endfunction

  function automatic int model_lat(input logic [N-1:0] b, input logic [2:0] s);
    if (s == 3'd3 || s == 3'd4) return 1 + ((int'(b) >= N) ? N : int'(b));
    return 1;
  endfunction

  // Issue one command, check latency and result, then hold off out_ready for
  // hold cycles (optionally pulsing in_valid with junk) before the handshake.
  task automatic run_cmd(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] s,
                         input int hold, input bit pulse);
    int           lat;
    int           exp_lat;
    logic [N+1:0] exp;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b want 1", in_ready);
    else passed++;
    A = a; B = b; S = s; in_valid = 1'b1; out_ready = 1'b0;
    exp_q.push_back(model(a, b, s));
    lat_q.push_back(model_lat(b, s));
    @(negedge clk);
    in_valid = 1'b0;
    A = N'($urandom); B = N'($urandom); S = 3'($urandom);
    lat = 1;
    while (out_valid !== 1'b1 && lat <= MAX_LAT) begin
      total++;
      if (in_ready !== 1'b0) $display("FAIL busy_in_ready: got %b want 0 (S=%0d)", in_ready, s);
      else passed++;
      @(negedge clk);
      lat++;
    end
    exp     = exp_q.pop_front();
    exp_lat = lat_q.pop_front();
    total++;
    if (out_valid !== 1'b1) begin
      $display("FAIL timeout: out_valid never rose for S=%0d A=%b B=%b", s, a, b);
      return;
    end
    passed++;
    total++;
    if (lat != exp_lat) $display("FAIL latency: S=%0d B=%b got %0d want %0d", s, b, lat, exp_lat);
    else passed++;
    total++;
    if ({ERR, Z, R} !== exp)
      $display("FAIL result: S=%0d A=%b B=%b got ERR=%b Z=%b R=%b want ERR=%b Z=%b R=%b",
               s, a, b, ERR, Z, R, exp[N+1], exp[N], exp[N-1:0]);
    else passed++;
    for (int i = 0; i < hold; i++) begin
      if (pulse) begin
        A = N'($urandom); B = N'($urandom); S = 3'($urandom_range(0, 4)); in_valid = 1'b1;
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ERR, Z, R} !== exp)
        $display("FAIL hold: cycle %0d got out_valid=%b in_ready=%b ERR=%b Z=%b R=%b want 1 0 %b",
                 i, out_valid, in_ready, ERR, Z, R, exp);
      else passed++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; S = '0;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || R !== '0 || Z !== 1'b0 || ERR !== 1'b0 ||
        dbg_state !== 2'd0)
      $display("FAIL reset_values: got in_ready=%b out_valid=%b R=%b Z=%b ERR=%b state=%0d want 1 0 0000 0 0 0",
               in_ready, out_valid, R, Z, ERR, dbg_state);
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_logic_ops();
    run_cmd(4'b1100, 4'b1010, 3'd0, 0, 1'b0);
    run_cmd(4'b1100, 4'b1010, 3'd1, 0, 1'b0);
    run_cmd(4'b1100, 4'b1010, 3'd2, 1, 1'b0);
    run_cmd(4'b0101, 4'b1010, 3'd0, 0, 1'b0);
  endtask

  task automatic test_shifts();
    run_cmd(4'b0011, 4'b0010, 3'd3, 0, 1'b0);
    run_cmd(4'b1000, 4'b0111, 3'd4, 0, 1'b0);
    run_cmd(4'b1010, 4'b0000, 3'd4, 0, 1'b0);
    run_cmd(4'b1011, 4'b0001, 3'd4, 0, 1'b0);
    run_cmd(4'b0001, 4'b0011, 3'd3, 0, 1'b0);
    run_cmd(4'b1111, 4'b0100, 3'd3, 0, 1'b0);
    run_cmd(4'b1111, 4'b1111, 3'd3, 0, 1'b0);
  endtask

  task automatic test_invalid();
    run_cmd(4'b1111, 4'b0000, 3'd6, 0, 1'b0);
    run_cmd(4'b1100, 4'b0110, 3'd2, 0, 1'b0);
    run_cmd(4'b0110, 4'b0011, 3'd5, 0, 1'b0);
    run_cmd(4'b0110, 4'b0011, 3'd7, 0, 1'b0);
    run_cmd(4'b0110, 4'b0011, 3'd1, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_cmd(4'b0110, 4'b0011, 3'd0, 3, 1'b1);
    run_cmd(4'b1001, 4'b0001, 3'd3, 3, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    A = 4'b0001; B = 4'b0011; S = 3'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (dbg_state !== 2'd1) $display("FAIL mid_shift_state: got %0d want 1", dbg_state);
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || R !== '0 || Z !== 1'b0 || ERR !== 1'b0)
      $display("FAIL mid_reset: got out_valid=%b in_ready=%b R=%b Z=%b ERR=%b want 0 1 0000 0 0",
               out_valid, in_ready, R, Z, ERR);
    else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset_hold_valid: got %b want 0", out_valid);
    else passed++;
    rst = 1'b1;
    run_cmd(4'b0101, 4'b0010, 3'd1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 25; i++)
      run_cmd(N'($urandom), N'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    test_reset();
    test_logic_ops();
    test_shifts();
    test_invalid();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
